// File: rtl/axi_wr_protocol_monitor_if.sv
// AXI write-channel bundle (AW/W/B) shared by masters, slaves and monitors.
// Monitors attach through the all-input monitor modport.
interface axi_wr_protocol_monitor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    wvalid;
  logic                    wready;
  logic                    wlast;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bresp
  );

  modport monitor (
    input awvalid, awready, awaddr, awlen,
    input wvalid, wready, wlast, wdata, wstrb,
    input bvalid, bready, bresp
  );
endinterface

// File: rtl/axi_wr_protocol_monitor.sv
// Passive AXI write-channel protocol monitor with sticky error capture.
// Optional payload stability checking: AXI_MON_STABILITY_CHECK_EN.
module axi_wr_protocol_monitor #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int TIMEOUT_CYCLES  = 100,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_wr_protocol_monitor_if.monitor axi,
  input  logic                 err_clear,
  output logic                 protocol_error,
  output logic [3:0]           error_code,
  output logic [15:0]          error_vec,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int QW  = PW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PBW = 16;

  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX =
    TW'(TIMEOUT_CYCLES);
  localparam logic [QW-1:0] Q_FULL =
    QW'(MAX_OUTSTANDING);

  localparam int E_AW_STUCK  = 1;
  localparam int E_W_STUCK   = 2;
  localparam int E_B_STUCK   = 3;
  localparam int E_WL_EARLY  = 4;
  localparam int E_WL_MISS   = 5;
  localparam int E_W_NO_AW   = 6;
  localparam int E_B_NO_W    = 7;
  localparam int E_AW_OVF    = 8;
  localparam int E_B_ERR     = 9;
  localparam int E_STABILITY = 10;

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign b_hs  = axi.bvalid && axi.bready;

  logic [7:0]    q_mem [MAX_OUTSTANDING];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [QW-1:0] q_cnt;
  logic          q_empty;
  logic          q_full;

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == Q_FULL);

  logic [7:0]     beat;
  logic [PBW-1:0] pend_b;
  logic [PBW-1:0] pend_b_nxt;

  logic       have_len;
  logic       bypass;
  logic [7:0] cur_len;
  logic       w_track;
  logic       at_len;
  logic       burst_end;
  logic       pop;
  logic       push;
  logic       aw_ovf;

  // An empty queue lets a same-cycle AW supply the length directly.
  assign bypass   = q_empty && aw_hs;
  assign have_len = !q_empty || aw_hs;
  assign cur_len  = q_empty ? axi.awlen
                            : q_mem[rd_ptr];
  assign w_track  = w_hs && have_len;
  assign at_len   = (beat == cur_len);

  assign burst_end = w_track &&
                     (axi.wlast || at_len);
  assign pop  = burst_end && !q_empty;
  assign push = aw_hs &&
                !(bypass && burst_end) &&
                (!q_full || pop);
  assign aw_ovf = aw_hs && q_full && !pop;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= axi.awlen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      q_cnt <= q_cnt + QW'(push) - QW'(pop);
    end
  end

  assign outstanding = q_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (w_track) begin
      beat <= burst_end ? 8'd0 : beat + 8'd1;
    end
  end

  always_comb begin
    pend_b_nxt = pend_b;
    if (burst_end && pend_b != '1)
      pend_b_nxt = pend_b_nxt + PBW'(1);
    if (b_hs && pend_b_nxt != '0)
      pend_b_nxt = pend_b_nxt - PBW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_b <= '0;
    else     pend_b <= pend_b_nxt;
  end

  logic [2:0]    stall;
  logic [2:0]    to_fire;
  logic [TW-1:0] to_cnt [3];

  assign stall[0] = axi.awvalid && !axi.awready;
  assign stall[1] = axi.wvalid  && !axi.wready;
  assign stall[2] = axi.bvalid  && !axi.bready;

  always_comb begin
    for (int i = 0; i < 3; i++)
      to_fire[i] = stall[i] && (to_cnt[i] == T_LAST);
  end

  // Counter parks at T_MAX so a long stall fires only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) to_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!stall[i])
          to_cnt[i] <= '0;
        else if (to_cnt[i] != T_MAX)
          to_cnt[i] <= to_cnt[i] + TW'(1);
      end
    end
  end

  logic stab_err;

`ifdef AXI_MON_STABILITY_CHECK_EN
  logic [2:0]              stall_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [7:0]              awlen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    wlast_q;
  logic [1:0]              bresp_q;
  logic                    aw_bad;
  logic                    w_bad;
  logic                    b_bad;

  assign aw_bad = stall_q[0] &&
                  (!axi.awvalid ||
                   axi.awaddr != awaddr_q ||
                   axi.awlen  != awlen_q);
  assign w_bad  = stall_q[1] &&
                  (!axi.wvalid ||
                   axi.wdata != wdata_q ||
                   axi.wstrb != wstrb_q ||
                   axi.wlast != wlast_q);
  assign b_bad  = stall_q[2] &&
                  (!axi.bvalid ||
                   axi.bresp != bresp_q);
  assign stab_err = aw_bad || w_bad || b_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
      bresp_q  <= '0;
    end else begin
      stall_q  <= stall;
      awaddr_q <= axi.awaddr;
      awlen_q  <= axi.awlen;
      wdata_q  <= axi.wdata;
      wstrb_q  <= axi.wstrb;
      wlast_q  <= axi.wlast;
      bresp_q  <= axi.bresp;
    end
  end
`else
  logic unused_payload;
  assign unused_payload = ^{axi.awaddr,
                            axi.wdata,
                            axi.wstrb};
  assign stab_err = 1'b0;
`endif

  logic [15:0] err_now;
  logic        err_any;
  logic [3:0]  first_code;

  always_comb begin
    err_now              = '0;
    err_now[E_AW_STUCK]  = to_fire[0];
    err_now[E_W_STUCK]   = to_fire[1];
    err_now[E_B_STUCK]   = to_fire[2];
    err_now[E_WL_EARLY]  = w_track && axi.wlast &&
                           !at_len;
    err_now[E_WL_MISS]   = w_track && !axi.wlast &&
                           at_len;
    err_now[E_W_NO_AW]   = w_hs && !have_len;
    err_now[E_B_NO_W]    = axi.bvalid &&
                           (pend_b == '0);
    err_now[E_AW_OVF]    = aw_ovf;
    err_now[E_B_ERR]     = b_hs && axi.bresp[1];
    err_now[E_STABILITY] = stab_err;
  end

  assign err_any = |err_now;

  always_comb begin
    first_code = '0;
    for (int i = 15; i >= 1; i--)
      if (err_now[i]) first_code = 4'(i);
  end

  // A clear coinciding with a new error restarts capture from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_error <= 1'b0;
      error_code     <= '0;
      error_vec      <= '0;
      error_count    <= '0;
    end else if (err_clear) begin
      protocol_error <= err_any;
      error_code     <= first_code;
      error_vec      <= err_now;
      error_count    <= CNT_WIDTH'(err_any);
    end else begin
      error_vec <= error_vec | err_now;
      if (err_any && !protocol_error) begin
        protocol_error <= 1'b1;
        error_code     <= first_code;
      end
      if (err_any && error_count != '1)
        error_count <= error_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi_wr_protocol_monitor.sv
// Randomised and directed bench for axi_wr_protocol_monitor.
// Reference model tracks bursts with a queue and counts stalls.
module tb_axi_wr_protocol_monitor;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int T  = 100;
  localparam int M  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          err_clear;
  logic          protocol_error;
  logic [3:0]    error_code;
  logic [15:0]   error_vec;
  logic [CW-1:0] error_count;
  logic [2:0]    outstanding;

  always #5 clk = ~clk;

  axi_wr_protocol_monitor_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) axi ();

  axi_wr_protocol_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(T), .MAX_OUTSTANDING(M),
    .CNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .axi(axi),
    .err_clear(err_clear),
    .protocol_error(protocol_error),
    .error_code(error_code),
    .error_vec(error_vec),
    .error_count(error_count),
    .outstanding(outstanding)
  );

  int tests = 0;
  int fails = 0;

  int q[$];
  int beat, pend;
  int st_aw, st_w, st_b;
  bit e_pe;
  int e_code;
  logic [15:0] e_vec;
  int e_cnt;
`ifdef AXI_MON_STABILITY_CHECK_EN
  bit p_aw, p_w, p_b;
  logic [AW-1:0] p_addr;
  logic [7:0] p_len;
  logic [DW-1:0] p_data;
  logic [DW/8-1:0] p_strb;
  logic p_last;
  logic [1:0] p_resp;
`endif

  task automatic model_reset();
    q.delete();
    beat = 0; pend = 0;
    st_aw = 0; st_w = 0; st_b = 0;
    e_pe = 0; e_code = 0; e_vec = '0; e_cnt = 0;
`ifdef AXI_MON_STABILITY_CHECK_EN
    p_aw = 0; p_w = 0; p_b = 0;
`endif
  endtask

  task automatic model_step();
    logic [15:0] e;
    bit awh, wh, bh, byp, have, endb, popped;
    int len, sz, lo;
    e = '0; len = 0; lo = 0;
    awh = axi.awvalid && axi.awready;
    wh  = axi.wvalid && axi.wready;
    bh  = axi.bvalid && axi.bready;
    sz  = q.size();
    if (axi.awvalid && !axi.awready) st_aw++;
    else st_aw = 0;
    if (axi.wvalid && !axi.wready) st_w++;
    else st_w = 0;
    if (axi.bvalid && !axi.bready) st_b++;
    else st_b = 0;
    if (st_aw == T) e[1] = 1'b1;
    if (st_w == T)  e[2] = 1'b1;
    if (st_b == T)  e[3] = 1'b1;
    have = 0; byp = 0; endb = 0; popped = 0;
    if (wh) begin
      if (sz > 0) begin
        len = q[0]; have = 1;
      end else if (awh) begin
        len = int'(axi.awlen); have = 1; byp = 1;
      end else e[6] = 1'b1;
    end
    if (have) begin
      if (axi.wlast && beat < len) e[4] = 1'b1;
      if (!axi.wlast && beat == len) e[5] = 1'b1;
      if (axi.wlast || beat == len) begin
        endb = 1; beat = 0;
      end else beat++;
    end
    if (endb && !byp) begin
      void'(q.pop_front()); popped = 1;
    end
    if (awh && !(byp && endb)) begin
      if (sz == M && !popped) e[8] = 1'b1;
      else q.push_back(int'(axi.awlen));
    end
    if (axi.bvalid && pend == 0) e[7] = 1'b1;
    if (bh && axi.bresp[1]) e[9] = 1'b1;
    if (endb) pend++;
    if (bh && pend > 0) pend--;
`ifdef AXI_MON_STABILITY_CHECK_EN
    if (p_aw && (!axi.awvalid || axi.awaddr !== p_addr ||
        axi.awlen !== p_len)) e[10] = 1'b1;
    if (p_w && (!axi.wvalid || axi.wdata !== p_data ||
        axi.wstrb !== p_strb || axi.wlast !== p_last))
      e[10] = 1'b1;
    if (p_b && (!axi.bvalid || axi.bresp !== p_resp))
      e[10] = 1'b1;
    p_aw = axi.awvalid && !axi.awready;
    p_w  = axi.wvalid && !axi.wready;
    p_b  = axi.bvalid && !axi.bready;
    p_addr = axi.awaddr; p_len = axi.awlen;
    p_data = axi.wdata; p_strb = axi.wstrb;
    p_last = axi.wlast; p_resp = axi.bresp;
`endif
    for (int i = 1; i < 16; i++)
      if (e[i]) begin lo = i; break; end
    if (err_clear) begin
      e_pe = (e != 0); e_code = lo;
      e_vec = e; e_cnt = (e != 0) ? 1 : 0;
    end else begin
      e_vec = e_vec | e;
      if (e != 0 && !e_pe) begin
        e_pe = 1; e_code = lo;
      end
      if (e != 0 && e_cnt < (2**CW - 1)) e_cnt++;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    axi.awvalid = 0; axi.awready = 0;
    axi.awaddr = '0; axi.awlen = '0;
    axi.wvalid = 0; axi.wready = 0; axi.wlast = 0;
    axi.wdata = '0; axi.wstrb = '0;
    axi.bvalid = 0; axi.bready = 0; axi.bresp = '0;
    err_clear = 0;
  endtask

  task automatic clear_errs();
    idle();
    err_clear = 1;
    cycle();
    err_clear = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    tests++;
    if ({protocol_error, error_code, error_vec,
         error_count, outstanding} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%h/%h/%h/%h want 0",
        protocol_error, error_code, error_vec,
        error_count, outstanding);
    end
    rst = 0;
    @(posedge clk); #1;
    tests++;
    if (protocol_error !== 1'b0 || outstanding !== 3'd0) begin
      fails++;
      $display("FAIL post_reset: pe=%b out=%0d want 0/0",
        protocol_error, outstanding);
    end
  endtask

  task automatic test_clean_burst();
    idle();
    axi.awvalid = 1; axi.awready = 1; axi.awlen = 8'd3;
    cycle();
    tests++;
    if (outstanding !== 3'd1) begin
      fails++;
      $display("FAIL clean_out1: got %0d want 1", outstanding);
    end
    idle();
    axi.wvalid = 1; axi.wready = 1;
    for (int i = 0; i < 4; i++) begin
      axi.wlast = (i == 3);
      cycle();
    end
    tests++;
    if (outstanding !== 3'd0) begin
      fails++;
      $display("FAIL clean_out0: got %0d want 0", outstanding);
    end
    idle();
    axi.bvalid = 1; axi.bready = 1;
    cycle();
    idle();
    cycle();
    tests++;
    if (protocol_error !== 1'b0 || error_count !== '0) begin
      fails++;
      $display("FAIL clean_noerr: pe=%b cnt=%0d want 0/0",
        protocol_error, error_count);
    end
  endtask

  task automatic test_early_wlast();
    clear_errs();
    axi.awvalid = 1; axi.awready = 1; axi.awlen = 8'd3;
    cycle();
    idle();
    axi.wvalid = 1; axi.wready = 1;
    cycle();
    axi.wlast = 1;
    cycle();
    tests++;
    if (protocol_error !== 1'b1 || error_code !== 4'd4 ||
        error_vec !== 16'h0010 || error_count !== 16'd1) begin
      fails++;
      $display("FAIL early_wlast: pe=%b code=%0d vec=%h cnt=%0d want 1/4/0010/1",
        protocol_error, error_code, error_vec, error_count);
    end
    tests++;
    if (outstanding !== 3'd0) begin
      fails++;
      $display("FAIL early_pop: got %0d want 0", outstanding);
    end
    idle();
    axi.bvalid = 1; axi.bready = 1;
    cycle();
    idle();
  endtask

  task automatic test_aw_stuck();
    clear_errs();
    axi.awvalid = 1; axi.awready = 0;
    for (int i = 1; i <= 150; i++) begin
      cycle();
      if (i == 99) begin
        tests++;
        if (protocol_error !== 1'b0) begin
          fails++;
          $display("FAIL stuck_early: pe=%b want 0 at 99",
            protocol_error);
        end
      end
      if (i == 100) begin
        tests++;
        if (error_code !== 4'd1 || error_count !== 16'd1) begin
          fails++;
          $display("FAIL stuck_fire: code=%0d cnt=%0d want 1/1",
            error_code, error_count);
        end
      end
    end
    tests++;
    if (error_count !== 16'd1 || error_vec !== 16'h0002) begin
      fails++;
      $display("FAIL stuck_once: cnt=%0d vec=%h want 1/0002",
        error_count, error_vec);
    end
    idle();
    cycle();
  endtask

  task automatic test_aw_overflow();
    clear_errs();
    axi.awvalid = 1; axi.awready = 1; axi.awlen = 8'd0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 4) begin
        tests++;
        if (outstanding !== 3'd4 || protocol_error !== 1'b0) begin
          fails++;
          $display("FAIL ovf_fill: out=%0d pe=%b want 4/0",
            outstanding, protocol_error);
        end
      end
    end
    tests++;
    if (error_code !== 4'd8 || outstanding !== 3'd4 ||
        error_count !== 16'd1) begin
      fails++;
      $display("FAIL ovf_5th: code=%0d out=%0d cnt=%0d want 8/4/1",
        error_code, outstanding, error_count);
    end
    err_clear = 1;
    axi.wvalid = 1; axi.wready = 1; axi.wlast = 1;
    cycle();
    err_clear = 0;
    tests++;
    if (outstanding !== 3'd4 || protocol_error !== 1'b0) begin
      fails++;
      $display("FAIL full_pushpop: out=%0d pe=%b want 4/0",
        outstanding, protocol_error);
    end
    axi.awvalid = 0;
    for (int i = 0; i < 4; i++) cycle();
    tests++;
    if (outstanding !== 3'd0) begin
      fails++;
      $display("FAIL ovf_drain: got %0d want 0", outstanding);
    end
    idle();
    axi.bvalid = 1; axi.bready = 1;
    for (int i = 0; i < 5; i++) cycle();
    idle();
    cycle();
    tests++;
    if (protocol_error !== 1'b0) begin
      fails++;
      $display("FAIL ovf_bdrain: pe=%b want 0", protocol_error);
    end
  endtask

  task automatic test_b_errors();
    clear_errs();
    axi.bvalid = 1; axi.bready = 0;
    cycle();
    tests++;
    if (error_code !== 4'd7 || error_vec !== 16'h0080) begin
      fails++;
      $display("FAIL b_no_w: code=%0d vec=%h want 7/0080",
        error_code, error_vec);
    end
    idle();
    axi.awvalid = 1; axi.awready = 1; axi.awlen = 8'd0;
    axi.wvalid = 1; axi.wready = 1; axi.wlast = 1;
    cycle();
    tests++;
    if (outstanding !== 3'd0 || error_count !== 16'd1 ||
        error_vec !== 16'h0080) begin
      fails++;
      $display("FAIL bypass: out=%0d cnt=%0d vec=%h want 0/1/0080",
        outstanding, error_count, error_vec);
    end
    clear_errs();
    tests++;
    if ({protocol_error, error_code, error_vec,
         error_count} !== '0) begin
      fails++;
      $display("FAIL err_clear: %b/%0d/%h/%0d want all 0",
        protocol_error, error_code, error_vec, error_count);
    end
    axi.bvalid = 1; axi.bready = 1; axi.bresp = 2'b10;
    cycle();
    tests++;
    if (error_code !== 4'd9 || error_vec !== 16'h0200 ||
        error_count !== 16'd1) begin
      fails++;
      $display("FAIL b_slverr: code=%0d vec=%h cnt=%0d want 9/0200/1",
        error_code, error_vec, error_count);
    end
    idle();
    cycle();
  endtask

  task automatic test_stability();
    logic [AW-1:0] a;
    logic exp_pe;
    logic [3:0] exp_code;
    clear_errs();
    a = 32'h1000_0000;
    axi.awvalid = 1; axi.awready = 0;
    for (int i = 0; i < 3; i++) begin
      axi.awaddr = a + AW'(4 * i);
      cycle();
    end
`ifdef AXI_MON_STABILITY_CHECK_EN
    exp_pe = 1'b1; exp_code = 4'd10;
`else
    exp_pe = 1'b0; exp_code = 4'd0;
`endif
    tests++;
    if (protocol_error !== exp_pe || error_code !== exp_code) begin
      fails++;
      $display("FAIL stability: pe=%b code=%0d want %b/%0d",
        protocol_error, error_code, exp_pe, exp_code);
    end
    idle();
    cycle();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 2000; n++) begin
      axi.awvalid = ($urandom % 3 == 0);
      axi.awready = $urandom % 2;
      axi.awlen   = 8'($urandom_range(0, 3));
      axi.awaddr  = $urandom;
      axi.wvalid  = $urandom % 2;
      axi.wready  = ($urandom % 4 != 0);
      axi.wlast   = ($urandom % 3 == 0);
      axi.wdata   = {$urandom, $urandom, $urandom, $urandom};
      axi.wstrb   = 16'($urandom);
      axi.bvalid  = ($urandom % 4 == 0);
      axi.bready  = $urandom % 2;
      axi.bresp   = 2'($urandom);
      err_clear   = ($urandom % 40 == 0);
      cycle();
      tests++;
      if ({protocol_error, error_code, error_vec,
           error_count, outstanding} !==
          {e_pe, 4'(e_code), e_vec, CW'(e_cnt),
           3'(q.size())}) begin
        fails++;
        if (bad < 10)
          $display("FAIL random[%0d]: got %b/%0d/%h/%0d/%0d want %b/%0d/%h/%0d/%0d",
            n, protocol_error, error_code, error_vec,
            error_count, outstanding, e_pe, e_code,
            e_vec, e_cnt, q.size());
        bad++;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_clean_burst();
    test_early_wlast();
    test_aw_stuck();
    test_aw_overflow();
    test_b_errors();
    test_stability();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
